pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It tracks in-flight register writes with a scoreboard and detects RAW/WAW hazards at issue from ID. It generates the stall and flush controls for IF, IF_ID and ID_EXE, handling branch redirects and data-memory wait states. It sits beside ID and control_unit and replaces the constant flush/select ties currently driven into IF_ID.

---
 rtl/pipe_ctrl_if.sv | 55 +++++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Pipeline-side bundle for the sequencing controller: ID
//               operands, WB retire, EXE redirect, memory wait, and the
//               stall/flush/issue controls plus scoreboard observation.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    // ID stage instruction description
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_re_i;
    logic        id_rs2_re_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    // WB retire
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic        wb_rd_we_i;
    // Redirect and memory wait
    logic        exe_redirect_i;
    logic        mem_busy_i;
    // Controls back to the pipeline
    logic        issue_o;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_exe_flush_o;
    logic        id_exe_stall_o;
    logic [31:0] pending_o;
    logic [15:0] hz_stall_cnt_o;

    // Pipeline datapath side
    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i,
               id_rs2_re_i, id_rd_addr_i, id_rd_we_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_we_i,
               exe_redirect_i, mem_busy_i,
        input  issue_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
               id_exe_flush_o, id_exe_stall_o, pending_o, hz_stall_cnt_o
    );

    // Controller side
    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_re_i,
               id_rs2_re_i, id_rd_addr_i, id_rd_we_i,
               wb_valid_i, wb_rd_addr_i, wb_rd_we_i,
               exe_redirect_i, mem_busy_i,
        output issue_o, pc_stall_o, if_id_stall_o, if_id_flush_o,
               id_exe_flush_o, id_exe_stall_o, pending_o, hz_stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencing controller for the 5-stage RV32I core.
//               Scoreboard-based RAW/WAW hazard detection at issue, branch
//               redirect flushing and data-memory freeze handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_redir;
    logic        w_redir_nxt;
    logic [31:0] r_pending;
    logic [31:0] w_pend_nxt;
    logic [15:0] r_hz_cnt;
    logic        w_cnt_inc;

    logic        w_wb_clr;
    logic [31:0] w_wb_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_pend_eff;
    logic        w_hazard;

    logic        w_issue;
    logic        w_pc_stall;
    logic        w_if_id_stall;
    logic        w_if_id_flush;
    logic        w_id_exe_flush;
    logic        w_id_exe_stall;

    // Effective scoreboard: a retiring WB write is visible to ID this cycle
    // through the write-through register file, so it no longer blocks.
    always_comb begin
        w_wb_clr   = bus.wb_valid_i & bus.wb_rd_we_i;
        w_wb_mask  = w_wb_clr ? (32'd1 << bus.wb_rd_addr_i) : 32'd0;
        w_pend_eff = r_pending & ~w_wb_mask;
        w_hazard   = bus.id_valid_i &
                     ((bus.id_rs1_re_i & w_pend_eff[bus.id_rs1_addr_i]) |
                      (bus.id_rs2_re_i & w_pend_eff[bus.id_rs2_addr_i]) |
                      (bus.id_rd_we_i  & w_pend_eff[bus.id_rd_addr_i]));
    end

    // Sequencing decision: reset > memory freeze > redirect > FLUSH > hazard.
    always_comb begin
        w_state_nxt    = ST_RUN;
        w_redir_nxt    = r_redir;
        w_cnt_inc      = 1'b0;
        w_issue        = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_exe_flush = 1'b0;
        w_id_exe_stall = 1'b0;
        if (rst_i) begin
            w_if_id_flush  = 1'b1;
            w_id_exe_flush = 1'b1;
            w_redir_nxt    = 1'b0;
        end else if (bus.mem_busy_i) begin
            // Whole pipe frozen; remember a redirect so it is not lost.
            w_state_nxt    = ST_HOLD;
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_exe_stall = 1'b1;
            if (bus.exe_redirect_i) begin
                w_redir_nxt = 1'b1;
            end
        end else if (bus.exe_redirect_i | r_redir) begin
            w_state_nxt    = ST_FLUSH;
            w_redir_nxt    = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_exe_flush = 1'b1;
        end else if (r_state == ST_FLUSH) begin
            // Second flushed cycle kills the wrong-path fetch still in flight.
            w_if_id_flush  = 1'b1;
            w_id_exe_flush = 1'b1;
        end else if (w_hazard) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_exe_flush = 1'b1;
            w_cnt_inc      = 1'b1;
        end else begin
            w_issue = bus.id_valid_i;
        end
    end

    // Scoreboard next value: retire clears first, so an issue set wins.
    always_comb begin
        w_set_mask = (w_issue & bus.id_rd_we_i & (bus.id_rd_addr_i != 5'd0)) ?
                     (32'd1 << bus.id_rd_addr_i) : 32'd0;
        w_pend_nxt = (r_pending & ~w_wb_mask) | w_set_mask;
    end

    // State, redirect latch, scoreboard and stall counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RUN;
            r_redir   <= 1'b0;
            r_pending <= 32'd0;
            r_hz_cnt  <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_redir   <= w_redir_nxt;
            r_pending <= {w_pend_nxt[31:1], 1'b0};
            if (w_cnt_inc) begin
                r_hz_cnt <= r_hz_cnt + 16'd1;
            end
        end
    end

    assign bus.issue_o        = w_issue;
    assign bus.pc_stall_o     = w_pc_stall;
    assign bus.if_id_stall_o  = w_if_id_stall;
    assign bus.if_id_flush_o  = w_if_id_flush;
    assign bus.id_exe_flush_o = w_id_exe_flush;
    assign bus.id_exe_stall_o = w_id_exe_stall;
    assign bus.pending_o      = r_pending;
    assign bus.hz_stall_cnt_o = r_hz_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: directed scenarios and
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pipe_ctrl_if u_if ();

    pipe_ctrl u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owed-work flags and a per-register busy array.
    bit m_pend [32];
    int m_cnt;
    bit m_owe_redirect;
    bit m_owe_flush;
    bit last_issue;
    bit last_iff;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        u_if.id_valid_i     = 1'b0;
        u_if.id_rs1_addr_i  = 5'd0;
        u_if.id_rs2_addr_i  = 5'd0;
        u_if.id_rs1_re_i    = 1'b0;
        u_if.id_rs2_re_i    = 1'b0;
        u_if.id_rd_addr_i   = 5'd0;
        u_if.id_rd_we_i     = 1'b0;
        u_if.wb_valid_i     = 1'b0;
        u_if.wb_rd_addr_i   = 5'd0;
        u_if.wb_rd_we_i     = 1'b0;
        u_if.exe_redirect_i = 1'b0;
        u_if.mem_busy_i     = 1'b0;
    endtask

    function automatic bit blocked(input logic [4:0] r);
        return m_pend[r] && !(u_if.wb_valid_i && u_if.wb_rd_we_i && u_if.wb_rd_addr_i == r);
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: check controls mid-cycle, advance model, check registers.
    task automatic step();
        bit hz, e_is, e_pcs, e_ifs, e_iff, e_idf, e_ids;
        logic [5:0] act;
        #1;
        hz = u_if.id_valid_i && ((u_if.id_rs1_re_i && blocked(u_if.id_rs1_addr_i)) ||
                                 (u_if.id_rs2_re_i && blocked(u_if.id_rs2_addr_i)) ||
                                 (u_if.id_rd_we_i  && blocked(u_if.id_rd_addr_i)));
        {e_is, e_pcs, e_ifs, e_iff, e_idf, e_ids} = 6'b0;
        if (rst) begin
            e_iff = 1; e_idf = 1;
        end else if (u_if.mem_busy_i) begin
            e_pcs = 1; e_ifs = 1; e_ids = 1;
        end else if (u_if.exe_redirect_i || m_owe_redirect || m_owe_flush) begin
            e_iff = 1; e_idf = 1;
        end else if (hz) begin
            e_pcs = 1; e_ifs = 1; e_idf = 1;
        end else begin
            e_is = u_if.id_valid_i;
        end
        act = {u_if.issue_o, u_if.pc_stall_o, u_if.if_id_stall_o,
               u_if.if_id_flush_o, u_if.id_exe_flush_o, u_if.id_exe_stall_o};
        chk("ctrl", {26'd0, act}, {26'd0, e_is, e_pcs, e_ifs, e_iff, e_idf, e_ids});
        last_issue = act[5];
        last_iff   = act[2];
        // Model state update for the coming edge
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_cnt = 0; m_owe_redirect = 0; m_owe_flush = 0;
        end else begin
            if (u_if.mem_busy_i) begin
                if (u_if.exe_redirect_i) m_owe_redirect = 1;
                m_owe_flush = 0;
            end else if (u_if.exe_redirect_i || m_owe_redirect) begin
                m_owe_redirect = 0; m_owe_flush = 1;
            end else if (m_owe_flush) begin
                m_owe_flush = 0;
            end else if (hz) begin
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (u_if.wb_valid_i && u_if.wb_rd_we_i) m_pend[u_if.wb_rd_addr_i] = 0;
            if (e_is && u_if.id_rd_we_i && u_if.id_rd_addr_i != 0) m_pend[u_if.id_rd_addr_i] = 1;
        end
        @(posedge clk);
        #1;
        chk("pending", u_if.pending_o, model_pend());
        chk("hz_cnt", {16'd0, u_if.hz_stall_cnt_o}, m_cnt);
        @(negedge clk);
    endtask

    task automatic id_instr(input logic [4:0] rs1, input bit re1, input logic [4:0] rd, input bit we);
        u_if.id_valid_i    = 1'b1;
        u_if.id_rs1_addr_i = rs1;
        u_if.id_rs1_re_i   = re1;
        u_if.id_rd_addr_i  = rd;
        u_if.id_rd_we_i    = we;
    endtask

    task automatic wb(input logic [4:0] rd);
        u_if.wb_valid_i   = 1'b1;
        u_if.wb_rd_addr_i = rd;
        u_if.wb_rd_we_i   = 1'b1;
    endtask

    initial begin
        int c0;
        int guard;
        n_vec = 0; n_err = 0;
        m_cnt = 0; m_owe_redirect = 0; m_owe_flush = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);

        // Reset held two cycles
        step();
        chk("rst_flush", {30'd0, u_if.if_id_flush_o, u_if.id_exe_flush_o}, 32'd3);
        step();
        rst = 1'b0;
        chk("rst_pending", u_if.pending_o, 32'd0);
        chk("rst_cnt", {16'd0, u_if.hz_stall_cnt_o}, 32'd0);
        id_instr(5'd1, 1'b1, 5'd0, 1'b0);
        step();
        chk("post_rst_issue", {31'd0, last_issue}, 32'd1);

        // RAW on x5: three stalls, issue in the WB cycle
        c0 = u_if.hz_stall_cnt_o;
        idle(); id_instr(5'd0, 1'b0, 5'd5, 1'b1); step();
        idle(); id_instr(5'd5, 1'b1, 5'd0, 1'b0);
        repeat (3) step();
        wb(5'd5); step();
        chk("raw_issue", {31'd0, last_issue}, 32'd1);
        chk("raw_cnt", u_if.hz_stall_cnt_o - c0, 32'd3);
        chk("raw_clear", {31'd0, u_if.pending_o[5]}, 32'd0);

        // x0 never pending
        idle(); id_instr(5'd0, 1'b0, 5'd0, 1'b1); step();
        idle(); id_instr(5'd0, 1'b1, 5'd0, 1'b0); step();
        chk("x0_issue", {31'd0, last_issue}, 32'd1);

        // WAW on x7
        idle(); id_instr(5'd0, 1'b0, 5'd7, 1'b1); step();
        repeat (2) step();
        wb(5'd7); step();
        chk("waw_pend", {31'd0, u_if.pending_o[7]}, 32'd1);
        idle(); wb(5'd7); step();

        // Redirect pulse in RUN
        idle(); u_if.id_valid_i = 1'b1; u_if.exe_redirect_i = 1'b1; step();
        u_if.exe_redirect_i = 1'b0; step();
        chk("flush_state", {31'd0, last_iff}, 32'd1);
        step();

        // Memory freeze with a redirect in its second cycle
        u_if.mem_busy_i = 1'b1; step();
        u_if.exe_redirect_i = 1'b1; step();
        u_if.exe_redirect_i = 1'b0; step(); step();
        u_if.mem_busy_i = 1'b0; step();
        chk("busy_exit_flush", {31'd0, last_iff}, 32'd1);
        step(); step();

        // Collision on x9: WB clear and issue set on the same edge
        idle(); id_instr(5'd0, 1'b0, 5'd9, 1'b1); step();
        wb(5'd9); step();
        chk("collision", {31'd0, u_if.pending_o[9]}, 32'd1);

        // Counter wrap: hold a hazard on x9 until the count rolls over
        idle(); id_instr(5'd9, 1'b1, 5'd0, 1'b0);
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(); guard++;
        end
        chk("preload", {16'd0, u_if.hz_stall_cnt_o}, 32'h0000FFFF);
        step();
        chk("wrap", {16'd0, u_if.hz_stall_cnt_o}, 32'd0);
        idle(); wb(5'd9); step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            u_if.id_valid_i     = ($urandom_range(0, 9) < 8);
            u_if.id_rs1_addr_i  = 5'($urandom_range(0, 7));
            u_if.id_rs2_addr_i  = 5'($urandom_range(0, 7));
            u_if.id_rs1_re_i    = 1'($urandom);
            u_if.id_rs2_re_i    = 1'($urandom);
            u_if.id_rd_addr_i   = 5'($urandom_range(0, 7));
            u_if.id_rd_we_i     = 1'($urandom);
            u_if.wb_valid_i     = ($urandom_range(0, 9) < 4);
            u_if.wb_rd_addr_i   = 5'($urandom_range(0, 7));
            u_if.wb_rd_we_i     = ($urandom_range(0, 9) < 8);
            u_if.exe_redirect_i = ($urandom_range(0, 19) == 0);
            u_if.mem_busy_i     = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
